audio_envelope_pwm: RTL and testbench

Downstream stage of the square-wave tone generator. Takes its 1-bit tone output and applies a gated ADSR volume envelope. The envelope amplitude is realised as 8-bit PWM duty on the tone, and the block drives the final 1-bit audio pin. The tone generator keeps its own enable; this block applies its own audio_en gating at the pin.

---
 rtl/audio_envelope_pwm.sv | 121 ++++++++++++
 tb/tb_audio_envelope_pwm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_envelope_pwm.sv
// Gated ADSR envelope applied to a 1-bit tone as 8-bit PWM duty, driving the audio pin.
// Optional AUDIO_ENV_MASTER_VOL_EN adds a 2-bit master volume shift on the PWM level.
module audio_envelope_pwm #(
  parameter int unsigned TICK_DIV      = 1024,
  parameter int unsigned ATTACK_STEP   = 8,
  parameter int unsigned DECAY_STEP    = 1,
  parameter int unsigned SUSTAIN_LEVEL = 128,
  parameter int unsigned RELEASE_STEP  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       audio_en,
  input  logic       tone_in,
  input  logic       gate,
`ifdef AUDIO_ENV_MASTER_VOL_EN
  input  logic [1:0] master_vol,
`endif
  output logic       audio_out,
  output logic [7:0] env_level,
  output logic [2:0] env_state,
  output logic       busy
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [8:0] ATK = 9'(ATTACK_STEP);
  localparam logic [8:0] DEC = 9'(DECAY_STEP);
  localparam logic [8:0] REL = 9'(RELEASE_STEP);
  localparam logic [7:0] SUS = 8'(SUSTAIN_LEVEL);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [7:0]    level_n;
  logic          gate_q;
  logic [TW-1:0] tick_cnt;
  logic [7:0]    pwm_cnt;
  logic          tick, rise, pwm_on;
  logic [8:0]    atk_sum, dec_diff, rel_diff;
  logic [7:0]    eff_level;

  assign tick      = (tick_cnt == TICK_LAST);
  assign rise      = gate & ~gate_q;
  assign atk_sum   = {1'b0, env_level} + ATK;
  assign dec_diff  = {1'b0, env_level} - DEC;
  assign rel_diff  = {1'b0, env_level} - REL;
  assign env_state = state;
  assign busy      = (state != S_IDLE);

`ifdef AUDIO_ENV_MASTER_VOL_EN
  assign eff_level = env_level >> (2'd3 - master_vol);
`else
  assign eff_level = env_level;
`endif

  assign pwm_on = (pwm_cnt < eff_level);

  // Bit 8 of the differences flags an underflow, so saturation is a single compare.
  always_comb begin
    state_n = state;
    level_n = env_level;
    if (rise) begin
      state_n = S_ATTACK;
    end else if (!gate && (state == S_ATTACK || state == S_DECAY || state == S_SUSTAIN)) begin
      state_n = S_RELEASE;
    end else if (tick) begin
      case (state)
        S_ATTACK: begin
          if (atk_sum[8] || atk_sum[7:0] == 8'hFF) begin
            level_n = 8'hFF;
            state_n = S_DECAY;
          end else begin
            level_n = atk_sum[7:0];
          end
        end
        S_DECAY: begin
          if (dec_diff[8] || dec_diff[7:0] <= SUS) begin
            level_n = SUS;
            state_n = S_SUSTAIN;
          end else begin
            level_n = dec_diff[7:0];
          end
        end
        S_RELEASE: begin
          if (rel_diff[8] || rel_diff[7:0] == 8'd0) begin
            level_n = '0;
            state_n = S_IDLE;
          end else begin
            level_n = rel_diff[7:0];
          end
        end
        default: level_n = env_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      env_level <= '0;
      gate_q    <= 1'b0;
      tick_cnt  <= '0;
      pwm_cnt   <= '0;
      audio_out <= 1'b0;
    end else begin
      state     <= state_n;
      env_level <= level_n;
      gate_q    <= gate;
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      pwm_cnt   <= pwm_cnt + 8'd1;
      audio_out <= audio_en & tone_in & pwm_on;
    end
  end

endmodule

// File: tb/tb_audio_envelope_pwm.sv
// Self-checking bench for audio_envelope_pwm: directed vector table, corner sequences,
// and randomized stimulus against an integer ADSR reference model.
module tb_audio_envelope_pwm;

  localparam int TD  = 4;
  localparam int ATK = 8;
  localparam int DEC = 1;
  localparam int SUS = 128;
  localparam int REL = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       audio_en = 1'b1;
  logic       tone_in = 1'b1;
  logic       gate = 1'b1;
  logic       audio_out;
  logic [7:0] env_level;
  logic [2:0] env_state;
  logic       busy;
`ifdef AUDIO_ENV_MASTER_VOL_EN
  logic [1:0] master_vol = 2'd3;
`endif

  audio_envelope_pwm #(
    .TICK_DIV(TD), .ATTACK_STEP(ATK), .DECAY_STEP(DEC),
    .SUSTAIN_LEVEL(SUS), .RELEASE_STEP(REL)
  ) dut (
    .clk(clk), .rst(rst), .audio_en(audio_en), .tone_in(tone_in), .gate(gate),
`ifdef AUDIO_ENV_MASTER_VOL_EN
    .master_vol(master_vol),
`endif
    .audio_out(audio_out), .env_level(env_level), .env_state(env_state), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_checks = 0;
  bit chk_each = 0;

  // Reference model: plain integers, phase counters derived from elapsed cycles.
  int m_state = 0, m_level = 0, m_gq = 0, m_phase = 0, m_pwm = 0, m_audio = 0;

  task automatic check(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int ns, nl, eff, vol;
    bit rise, tick;
    if (rst) begin
      m_state = 0; m_level = 0; m_gq = 0; m_phase = 0; m_pwm = 0; m_audio = 0;
    end else begin
      vol = 3;
`ifdef AUDIO_ENV_MASTER_VOL_EN
      vol = int'(master_vol);
`endif
      eff = m_level / (1 << (3 - vol));
      m_audio = (audio_en && tone_in && (m_pwm < eff)) ? 1 : 0;
      rise = gate && (m_gq == 0);
      tick = (m_phase == TD - 1);
      ns = m_state; nl = m_level;
      if (rise) ns = 1;
      else if (!gate && (m_state >= 1 && m_state <= 3)) ns = 4;
      else if (tick) begin
        case (m_state)
          1: begin nl = (m_level + ATK > 255) ? 255 : m_level + ATK; if (nl == 255) ns = 2; end
          2: begin nl = (m_level - DEC < SUS) ? SUS : m_level - DEC; if (nl == SUS) ns = 3; end
          4: begin nl = (m_level - REL < 0) ? 0 : m_level - REL; if (nl == 0) ns = 0; end
          default: nl = m_level;
        endcase
      end
      m_state = ns; m_level = nl;
      m_gq = gate ? 1 : 0;
      m_phase = (m_phase + 1) % TD;
      m_pwm = (m_pwm + 1) % 256;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    if (chk_each) begin
      check("rand_level", env_level, m_level);
      check("rand_state", env_state, m_state);
      check("rand_busy", busy, (m_state != 0) ? 1 : 0);
      check("rand_audio", audio_out, m_audio);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst = 1'b1; gate = 1'b0;
    steps(3);
    rst = 1'b0;
  endtask

  // Brings a note to RELEASE at level 40, with the first RELEASE tick 4 edges away.
  task automatic to_release40(input string tag);
    do_reset();
    step();
    gate = 1'b1;
    steps(22);
    check({tag, "_atk40_state"}, env_state, 1);
    check({tag, "_atk40_level"}, env_level, 40);
    gate = 1'b0;
    step();
    check({tag, "_rel_state"}, env_state, 4);
    check({tag, "_rel_level"}, env_level, 40);
  endtask

  typedef struct {
    bit rst, gate, tone, en;
    int ncyc;
    int exp_state, exp_level, exp_busy;
    bit chk_aud;
    int exp_aud;
  } vec_t;

  vec_t vecs[11];
  int cnt;

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vecs[0]  = '{1, 1, 1, 1,   3, 0,   0, 0, 1, 0};
    vecs[1]  = '{0, 0, 1, 1,   1, 0,   0, 0, 1, 0};
    vecs[2]  = '{0, 1, 1, 1,   1, 1,   0, 1, 0, 0};
    vecs[3]  = '{0, 1, 1, 1,   2, 1,   8, 1, 0, 0};
    vecs[4]  = '{0, 1, 1, 1, 120, 1, 248, 1, 0, 0};
    vecs[5]  = '{0, 1, 1, 1,   4, 2, 255, 1, 0, 0};
    vecs[6]  = '{0, 1, 1, 1, 508, 3, 128, 1, 0, 0};
    vecs[7]  = '{0, 1, 1, 1,  40, 3, 128, 1, 0, 0};
    vecs[8]  = '{0, 0, 1, 1,   1, 4, 128, 1, 0, 0};
    vecs[9]  = '{0, 0, 1, 1, 254, 4,   2, 1, 0, 0};
    vecs[10] = '{0, 0, 1, 1,   1, 0,   0, 0, 1, 0};

    for (int v = 0; v < 11; v++) begin
      rst = vecs[v].rst; gate = vecs[v].gate; tone_in = vecs[v].tone; audio_en = vecs[v].en;
      steps(vecs[v].ncyc);
      check($sformatf("vec%0d_state", v), env_state, vecs[v].exp_state);
      check($sformatf("vec%0d_level", v), env_level, vecs[v].exp_level);
      check($sformatf("vec%0d_busy", v), busy, vecs[v].exp_busy);
      if (vecs[v].chk_aud) check($sformatf("vec%0d_audio", v), audio_out, vecs[v].exp_aud);
    end

    // Gate drops on a tick edge: level must not move that cycle.
    to_release40("early");
    steps(3);
    check("early_hold_level", env_level, 40);
    step();
    check("early_tick_level", env_level, 38);

    // Legato retrigger from RELEASE keeps the level.
    to_release40("retrig");
    gate = 1'b1;
    step();
    check("retrig_state", env_state, 1);
    check("retrig_level", env_level, 40);
    steps(3);
    check("retrig_tick_level", env_level, 48);

    // PWM duty at SUSTAIN 128.
    do_reset();
    tone_in = 1'b1; audio_en = 1'b1;
    step();
    gate = 1'b1;
    for (int i = 0; i < 2000 && env_state != 3'd3; i++) step();
    check("sus_reached_state", env_state, 3);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin step(); if (audio_out) cnt++; end
    check("duty_128", cnt, 128);
    audio_en = 1'b0;
    step();
    check("en_off_audio", audio_out, 0);
    audio_en = 1'b1; tone_in = 1'b0;
    cnt = 0;
    for (int i = 0; i < 256; i++) begin step(); if (audio_out) cnt++; end
    check("tone_low_duty", cnt, 0);
    tone_in = 1'b1;
`ifdef AUDIO_ENV_MASTER_VOL_EN
    master_vol = 2'd1;
    step();
    cnt = 0;
    for (int i = 0; i < 256; i++) begin step(); if (audio_out) cnt++; end
    check("mvol1_duty", cnt, 32);
    master_vol = 2'd3;
    step();
    cnt = 0;
    for (int i = 0; i < 256; i++) begin step(); if (audio_out) cnt++; end
    check("mvol3_duty", cnt, 128);
`endif
    gate = 1'b1;
    step();
    check("gate_held_state", env_state, 3);

    // Randomized run against the model, every output every cycle.
    chk_each = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 149) == 0) gate = ~gate;
      tone_in  = 1'($urandom_range(0, 1));
      audio_en = ($urandom_range(0, 15) != 0);
      rst      = ($urandom_range(0, 1499) == 0);
`ifdef AUDIO_ENV_MASTER_VOL_EN
      if ($urandom_range(0, 99) == 0) master_vol = 2'($urandom_range(0, 3));
`endif
      step();
    end
    chk_each = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
